// File: rtl/riscv_pkg.sv
// Shared RV32I front-end types: NOP encoding, fetch FSM states and the
// {pc, inst} record carried from instruction memory to decode.
package riscv_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect from
// control logic, and the valid/ready instruction handoff to decode.
interface fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_valid_o;
  logic        inst_ready_i;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    input  redirect_i, redirect_pc_i,
    output inst_o, pc_o, inst_valid_o,
    input  inst_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    output redirect_i, redirect_pc_i,
    input  inst_o, pc_o, inst_valid_o,
    output inst_ready_i
  );
endinterface

// File: rtl/fetch_unit_fifo.sv
// Small first-word-fall-through FIFO of fetched {pc, inst} entries with a
// synchronous flush that wins over any push or pop in the same cycle.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_entry_t  push_data_i,
  input  logic          pop_i,
  output fetch_entry_t  head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return PW'(0);
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == CW'(0));
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = PW'(0);
      rd_ptr_d = PW'(0);
      cnt_d    = CW'(0);
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= PW'(0);
      rd_ptr_q <= PW'(0);
      cnt_q    <= CW'(0);
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: owns the fetch PC, issues in-order word
// requests, buffers responses with their PC and squashes wrong-path words.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic          clk_i,
  input logic          rst_i,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0] outst_q, outst_d, discard_q, discard_d;

  logic [CW-1:0] fifo_cnt;
  logic [CW:0]   in_use;
  logic          req, grant, resp_ok, keep, pop, fifo_full, fifo_empty;
  logic [31:0]   target;
  fetch_entry_t  head, push_entry;

  // Capacity counts every in-flight word so a response always finds a slot.
  assign in_use     = {1'b0, outst_q} + {1'b0, fifo_cnt};
  assign req        = (state_q != RESET) && (in_use < (CW + 1)'(DEPTH));
  assign grant      = req & bus.imem_gnt_i;
  assign resp_ok    = bus.imem_rvalid_i && (outst_q != CW'(0));
  assign keep       = resp_ok && (discard_q == CW'(0)) && !bus.redirect_i && !fifo_full;
  assign pop        = ~fifo_empty & bus.inst_ready_i;
  assign target     = word_align(bus.redirect_pc_i);
  assign push_entry = '{pc: resp_pc_q, inst: bus.imem_rdata_i};

  fetch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (bus.redirect_i),
    .push_i      (keep),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_cnt)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    discard_d  = discard_q;
    outst_d    = outst_q + CW'(grant) - CW'(resp_ok);
    if (bus.redirect_i) begin
      // Everything still outstanding after this cycle belongs to the old path.
      fetch_pc_d = target;
      resp_pc_d  = target;
      discard_d  = outst_d;
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (keep) begin
        resp_pc_d = resp_pc_q + 32'd4;
      end else if (resp_ok && (discard_q != CW'(0))) begin
        discard_d = discard_q - CW'(1);
      end else begin
        resp_pc_d = resp_pc_q;
      end
    end
    case (state_q)
      RESET:      state_d = RUN;
      RUN, DRAIN: state_d = (discard_d != CW'(0)) ? DRAIN : RUN;
      default:    state_d = RESET;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= RESET;
      fetch_pc_q <= word_align(RESET_PC);
      resp_pc_q  <= word_align(RESET_PC);
      outst_q    <= CW'(0);
      discard_q  <= CW'(0);
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  assign bus.imem_req_o   = req;
  assign bus.imem_addr_o  = word_align(fetch_pc_q);
  assign bus.inst_valid_o = ~fifo_empty;
  assign bus.inst_o       = fifo_empty ? NOP_INST : head.inst;
  assign bus.pc_o         = fifo_empty ? resp_pc_q : head.pc;

endmodule
